// File: rtl/video_ram_arbiter.sv
// Single-port video RAM arbiter: shares one RAM between the video fetch path and a CPU port.
// Video wins during active display, the CPU wins in blanking, and a starve counter forces CPU grants.
module video_ram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        hbl,
    input  logic        vbl,
    input  logic        vid_req,
    input  logic [10:0] vid_addr,
    output logic        vid_valid,
    output logic [7:0]  vid_data,
    output logic        vid_drop,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic [10:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VID,
        GNT_CPU
    } grant_t;

    grant_t      grant;
    logic        active;
    logic        cpu_pend;
    logic [3:0]  starve;
    logic        s1_vid;
    logic        s1_cpu;
    logic        s1_rd;
    logic        s1_drop;
    logic        ack_rd;
    logic [7:0]  vid_hold;
    logic [7:0]  cpu_hold;

    assign active = !hbl && !vbl;

    // A CPU transaction blocks re-arbitration from its grant until the cycle after its ack.
    assign cpu_pend = cpu_req && !s1_cpu && !cpu_ack;

    always_comb begin
        grant = GNT_NONE;
        if (cpu_pend && starve == 4'hF) begin
            grant = GNT_CPU;
        end else if (active) begin
            if (vid_req)
                grant = GNT_VID;
            else if (cpu_pend)
                grant = GNT_CPU;
        end else begin
            if (cpu_pend)
                grant = GNT_CPU;
            else if (vid_req)
                grant = GNT_VID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_din   <= '0;
            s1_vid    <= 1'b0;
            s1_cpu    <= 1'b0;
            s1_rd     <= 1'b0;
            s1_drop   <= 1'b0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            ack_rd    <= 1'b0;
            vid_drop  <= 1'b0;
            vid_hold  <= '0;
            cpu_hold  <= '0;
            starve    <= '0;
        end else begin
            ram_we <= (grant == GNT_CPU) && cpu_we;
            if (grant == GNT_VID) begin
                ram_addr <= vid_addr;
            end else if (grant == GNT_CPU) begin
                ram_addr <= cpu_addr;
                if (cpu_we)
                    ram_din <= cpu_din;
            end

            s1_vid    <= (grant == GNT_VID);
            s1_cpu    <= (grant == GNT_CPU);
            s1_rd     <= (grant == GNT_CPU) && !cpu_we;
            s1_drop   <= vid_req && (grant != GNT_VID);
            vid_valid <= s1_vid;
            cpu_ack   <= s1_cpu;
            ack_rd    <= s1_rd;
            vid_drop  <= s1_drop;

            if (vid_valid)
                vid_hold <= ram_dout;
            if (ack_rd)
                cpu_hold <= ram_dout;

            if (!cpu_req || grant == GNT_CPU)
                starve <= '0;
            else if (cpu_pend && starve != 4'hF)
                starve <= starve + 4'd1;
        end
    end

    // RAM data arrives in the result slot itself, so it is passed straight through and then held.
    assign vid_data = vid_valid ? ram_dout : vid_hold;
    assign cpu_dout = ack_rd ? ram_dout : cpu_hold;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Directed bench for video_ram_arbiter with a behavioural synchronous RAM attached to the RAM port.
module tb_video_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hbl, vbl, vid_req, cpu_req, cpu_we;
    logic [10:0] vid_addr, cpu_addr, ram_addr;
    logic [7:0]  cpu_din, vid_data, cpu_dout, ram_din, ram_dout;
    logic        vid_valid, vid_drop, cpu_ack, ram_we;

    logic [7:0]  mem [0:2047];
    int          compared = 0;
    int          mismatched = 0;

    video_ram_arbiter dut (
        .clk(clk), .reset(reset), .hbl(hbl), .vbl(vbl),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
        .vid_data(vid_data), .vid_drop(vid_drop),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic h, input logic v, input logic vr,
                                 input logic [10:0] va, input logic cr, input logic cw,
                                 input logic [10:0] ca, input logic [7:0] cd);
        hbl = h; vbl = v; vid_req = vr; vid_addr = va;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [10:0] burst_addr [0:3];
    logic [7:0]  burst_data [0:3];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[11'h123] = 8'h5A;
        mem[11'h010] = 8'h11;
        mem[11'h020] = 8'h22;
        ram_dout = 8'h00;
        burst_addr[0] = 11'h123; burst_addr[1] = 11'h7FF;
        burst_addr[2] = 11'h010; burst_addr[3] = 11'h020;
        burst_data[0] = 8'h5A;   burst_data[1] = 8'h3C;
        burst_data[2] = 8'h11;   burst_data[3] = 8'h22;

        reset = 1'b1;
        applyStimulus(0, 0, 0, 11'h0, 0, 0, 11'h0, 8'h0);
        tick; tick; tick;
        checkOutput("rst_vid_valid", vid_valid, 0);
        checkOutput("rst_vid_drop", vid_drop, 0);
        checkOutput("rst_cpu_ack", cpu_ack, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_din", ram_din, 0);
        checkOutput("rst_cpu_dout", cpu_dout, 0);
        checkOutput("rst_vid_data", vid_data, 0);

        // Blanking CPU read beats a simultaneous video request; first cycle after reset.
        reset = 1'b0;
        applyStimulus(1, 0, 1, 11'h010, 1, 0, 11'h123, 8'h0);
        tick;
        checkOutput("blank_ram_addr", ram_addr, 11'h123);
        checkOutput("blank_ram_we", ram_we, 0);
        applyStimulus(1, 0, 0, 11'h010, 1, 0, 11'h123, 8'h0);
        tick;
        checkOutput("blank_cpu_ack", cpu_ack, 1);
        checkOutput("blank_cpu_dout", cpu_dout, 8'h5A);
        checkOutput("blank_vid_drop", vid_drop, 1);
        checkOutput("blank_vid_valid", vid_valid, 0);
        tick;
        checkOutput("held_no_ack_n3", cpu_ack, 0);
        applyStimulus(1, 0, 0, 11'h010, 0, 0, 11'h123, 8'h0);
        tick;
        checkOutput("held_no_ack_n4", cpu_ack, 0);
        checkOutput("cpu_dout_hold", cpu_dout, 8'h5A);

        // Active-display CPU write when video is idle, then video reads it back.
        applyStimulus(0, 0, 0, 11'h0, 1, 1, 11'h7FF, 8'h3C);
        tick;
        checkOutput("wr_ram_we", ram_we, 1);
        checkOutput("wr_ram_din", ram_din, 8'h3C);
        checkOutput("wr_ram_addr", ram_addr, 11'h7FF);
        tick;
        checkOutput("wr_ram_we_once", ram_we, 0);
        checkOutput("wr_cpu_ack", cpu_ack, 1);
        checkOutput("wr_cpu_dout_kept", cpu_dout, 8'h5A);
        applyStimulus(0, 0, 1, 11'h7FF, 0, 0, 11'h0, 8'h0);
        tick;
        checkOutput("rb_ram_addr", ram_addr, 11'h7FF);
        applyStimulus(0, 0, 0, 11'h0, 0, 0, 11'h0, 8'h0);
        tick;
        checkOutput("rb_vid_valid", vid_valid, 1);
        checkOutput("rb_vid_data", vid_data, 8'h3C);

        // Four back-to-back video fetches with no CPU traffic.
        for (int i = 0; i < 7; i++) begin
            if (i >= 2) begin
                checkOutput("burst_vid_valid", vid_valid, (i < 6) ? 16'd1 : 16'd0);
                if (i < 6)
                    checkOutput("burst_vid_data", vid_data, burst_data[i-2]);
                checkOutput("burst_vid_drop", vid_drop, 0);
            end
            applyStimulus(0, 0, (i < 4), burst_addr[(i < 4) ? i : 0], 0, 0, 11'h0, 8'h0);
            tick;
        end

        // Continuous video during active display starves the CPU until the counter saturates.
        for (int k = 0; k < 20; k++) begin
            if (k == 15)
                checkOutput("starve_sat", dut.starve, 4'hF);
            if (k == 16) begin
                checkOutput("starve_clear", dut.starve, 0);
                checkOutput("forced_ram_addr", ram_addr, 11'h010);
            end
            if (k >= 2) begin
                checkOutput("starve_vid_valid", vid_valid, (k != 17) ? 16'd1 : 16'd0);
                checkOutput("starve_vid_drop", vid_drop, (k == 17) ? 16'd1 : 16'd0);
                checkOutput("starve_cpu_ack", cpu_ack, (k == 17) ? 16'd1 : 16'd0);
            end
            if (k == 17)
                checkOutput("starve_cpu_dout", cpu_dout, 8'h11);
            if (k < 18)
                applyStimulus(0, 0, 1, 11'h020, 1, 0, 11'h010, 8'h0);
            else
                applyStimulus(0, 0, 0, 11'h0, 0, 0, 11'h0, 8'h0);
            tick;
        end

        // Reset lands while a CPU read is in flight.
        applyStimulus(1, 0, 0, 11'h0, 1, 0, 11'h123, 8'h0);
        tick;
        reset = 1'b1;
        tick;
        checkOutput("mid_rst_cpu_ack", cpu_ack, 0);
        checkOutput("mid_rst_ram_addr", ram_addr, 0);
        checkOutput("mid_rst_cpu_dout", cpu_dout, 0);
        checkOutput("mid_rst_vid_data", vid_data, 0);
        checkOutput("mid_rst_ram_we", ram_we, 0);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 11'h0, 1, 0, 11'h010, 8'h0);
        tick;
        tick;
        checkOutput("post_rst_cpu_ack", cpu_ack, 1);
        checkOutput("post_rst_cpu_dout", cpu_dout, 8'h11);
        applyStimulus(0, 0, 0, 11'h0, 0, 0, 11'h0, 8'h0);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/video_ram_arbiter.md
VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 clk  in  1  system clock; all logic rises on posedge clk.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 hbl  in  1  horizontal blank from video timing.
REQ-004 vbl  in  1  vertical blank from video timing.
REQ-005 vid_req  in  1  video fetch request; single-cycle, may assert every cycle.
REQ-006 vid_addr  in  11  video fetch address.
REQ-007 vid_valid  out  1  one-cycle pulse; vid_data valid.
REQ-008 vid_data  out  8  video read data.
REQ-009 vid_drop  out  1  one-cycle pulse; a vid_req was not serviced.
REQ-010 cpu_req  in  1  CPU request; held high until cpu_ack.
REQ-011 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-012 cpu_addr  in  11  CPU address.
REQ-013 cpu_din  in  8  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle pulse; transaction complete.
REQ-015 cpu_dout  out  8  CPU read data; valid with cpu_ack on reads.
REQ-016 ram_addr  out  11  single-port RAM address, registered.
REQ-017 ram_we  out  1  RAM write enable, registered.
REQ-018 ram_din  out  8  RAM write data, registered.
REQ-019 ram_dout  in  8  RAM read data, valid 1 cycle after ram_addr.

Function
REQ-020 active = !hbl && !vbl; sampled in the same cycle as the requests.
REQ-021 Arbitration runs every clk cycle (not gated by pixel enable); at most one grant per cycle.
REQ-022 cpu_pend = cpu_req && no CPU transaction in flight; a transaction is in flight from grant cycle N through its ack cycle N+2.
REQ-023 active, starve counter < 15: video has priority; CPU is granted only when cpu_pend && !vid_req.
REQ-024 Blanking: CPU has priority; video is granted only when vid_req && !cpu_pend.
REQ-025 Grant at cycle N: ram_addr/ram_we/ram_din are driven at N+1; ram_we = 1 only for a CPU write, for exactly one cycle.
REQ-026 Video grant at N: vid_valid = 1 and vid_data = ram_dout at N+2; fixed latency 2; back-to-back grants produce back-to-back pulses.
REQ-027 CPU grant at N: cpu_ack pulses at N+2 for both reads and writes; for reads, cpu_dout = ram_dout at N+2.
REQ-028 cpu_dout holds its last read value between acks.
REQ-029 Starve counter: 4-bit, saturating.
  - Increments each cycle cpu_pend && not granted.
  - Clears on CPU grant, or when cpu_req = 0.
REQ-030 Counter == 15 with cpu_pend: CPU is granted regardless of active/vid_req.
REQ-031 Any cycle with vid_req = 1 and no video grant: vid_drop pulses at N+2, aligned to the slot where vid_valid would have been.
REQ-032 cpu_req high during an in-flight transaction: not re-arbitrated until the cycle after cpu_ack; the CPU deasserts or presents a new request on that cycle.
REQ-033 Idle cycles (no grant): ram_we = 0; ram_addr holds its previous value.
REQ-034 An hbl/vbl transition only affects arbitration from the cycle it is sampled; in-flight transactions complete unchanged.

Reset
REQ-035 While reset = 1 (next cycle onward): vid_valid, vid_drop, cpu_ack, ram_we = 0; ram_addr, ram_din, cpu_dout, vid_data = 0; starve counter = 0; in-flight pipeline cleared.
REQ-036 Reset mid-transaction: the pending ack/valid is never produced, and no RAM write occurs after the reset cycle.
REQ-037 First grant is possible in the first cycle after reset deasserts.

Verification
REQ-038 Blanking (hbl=1), CPU read addr 0x123, RAM[0x123]=0x5A, vid_req also high -> CPU granted; ram_addr=0x123 at N+1; cpu_ack=1 and cpu_dout=0x5A at N+2; vid_drop=1 at N+2.
REQ-039 Active, vid_req every cycle, cpu_req held -> 15 video grants; CPU forced grant on the 16th cycle; exactly one vid_drop; counter returns to 0.
REQ-040 Active, CPU write 0x3C to addr 0x7FF in a cycle with vid_req=0 -> ram_we=1 for one cycle with ram_din=0x3C at N+1; cpu_ack at N+2; a subsequent video read of 0x7FF returns 0x3C.
REQ-041 Active, vid_req pulses on 4 consecutive cycles, no CPU -> 4 consecutive vid_valid pulses, each 2 cycles after its request; no vid_drop.
REQ-042 CPU read granted, reset asserted at N+1 -> no cpu_ack at N+2; all outputs at reset values.
REQ-043 cpu_req held high across its ack -> exactly one cpu_ack per transaction; no grant in the ack cycle.
